mdu_ctrl: RTL and testbench

- Iterative multiply/divide sequencer owning the architectural HI/LO registers of the CPU.
- Executes MULT, MULTU, DIV and DIVU over 33 cycles, plus single-cycle MTHI and MTLO.
- Sits beside the ALU and is started by ctrl decode.
- Raises a stall to hold pc while a HI/LO consumer or a new mul/div op waits on an in-flight operation.

---
 rtl/mdu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus MTHI/MTLO.
// 32 radix-2 steps in CALC, sign fix-up and HI/LO write in FIX.
`default_nettype none

module mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_use,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               ovf;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

  // acc holds {upper product, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};

  always_comb begin
    step_acc = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH])
        step_acc = {acc[2*WIDTH-2:0], 1'b0};
      else
        step_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign prod_fix = neg_q ? -acc : acc;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        res_hi = a_raw;
        res_lo = ALL_ONES;
      end else if (ovf) begin
        res_hi = '0;
        res_lo = MIN_NEG;
      end else begin
        res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div <= op[1];
                acc    <= op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                m      <= op[1] ? b_abs : a_abs;
                a_raw  <= a;
                neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= signed_op && a[WIDTH-1];
                dz     <= (b == '0);
                ovf    <= (op == OP_DIV) && (a == MIN_NEG) && (b == ALL_ONES);
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= step_acc;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP)
              state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall = busy && (hilo_use || start);

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against an arithmetic model.
`default_nettype none

module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_use;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  integer      checks = 0;
  integer      errors = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_use(hilo_use), .flush(flush), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  // Architectural result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                              input logic [63:0] prev);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = prev;
    case (o)
      3'd0: res = 64'(sx * sy);
      3'd1: res = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: res = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      3'd4: res = {x, prev[31:0]};
      3'd5: res = {prev[63:32], x};
      default: res = prev;
    endcase
    return res;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] expv;
    int n;
    expv = ref_result(o, x, y, {hi_m, lo_m});
    issue(o, x, y);
    if (o < 3'd4) begin
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== 33) begin errors++; $display("FAIL %s busy_len: got %0d cycles, expected 33", name, n); end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b, expected 1", name, done); end
    end else begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL %s idle_flags: got busy=%b done=%b, expected 0 0", name, busy, done);
      end
    end
    checks++;
    if ({hi, lo} !== expv) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, expv[63:32], expv[31:0]);
    end
    {hi_m, lo_m} = expv;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; hilo_use = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      errors++; $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b stall=%b, expected all 0", hi, lo, busy, done, stall);
    end
  endtask

  task automatic test_directed;
    run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_const: got %h%h, expected ffffffffffffffeb", hi, lo); end
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_const: got %h%h, expected fffffffffffffffd", hi, lo); end
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0", 3'd3, 32'd100, 32'd0);
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
    run_op("mtlo", 3'd5, 32'h1234_5678, 32'd0);
    run_op("mthi", 3'd4, 32'hCAFE_F00D, 32'd0);
    run_op("nop6", 3'd6, 32'h1111_1111, 32'd3);
  endtask

  task automatic test_back_to_back;
    logic [63:0] expv;
    int n;
    run_op("b2b_first", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // still in the done cycle: issue the next op now
    start = 1'b1; op = 3'd1; a = 32'h0001_0003; b = 32'h0000_0005;
    expv = ref_result(3'd1, a, b, {hi_m, lo_m});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b, expected 1", busy); end
    n = 1;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 33 || done !== 1'b1) begin errors++; $display("FAIL b2b_len: got %0d cycles done=%b, expected 33 1", n, done); end
    checks++;
    if ({hi, lo} !== expv) begin errors++; $display("FAIL b2b_result: got %h%h, expected %h", hi, lo, expv); end
    {hi_m, lo_m} = expv;
  endtask

  task automatic test_stall_ignore;
    logic [63:0] expv;
    int n;
    expv = ref_result(3'd2, 32'd1000, 32'hFFFF_FFF9, {hi_m, lo_m});
    issue(3'd2, 32'd1000, 32'hFFFF_FFF9);
    repeat (3) @(negedge clk);
    hilo_use = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_hilo: got %b, expected 1", stall); end
    hilo_use = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_start: got %b, expected 1", stall); end
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      checks++;
      if (hi !== hi_m) begin errors++; $display("FAIL hi_hold: got %h, expected %h", hi, hi_m); end
      n++;
      @(negedge clk);
    end
    hilo_use = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL done_nostall: got done=%b stall=%b, expected 1 0", done, stall); end
    hilo_use = 1'b0;
    checks++;
    if ({hi, lo} !== expv) begin errors++; $display("FAIL stall_div_result: got %h%h, expected %h", hi, lo, expv); end
    {hi_m, lo_m} = expv;
  endtask

  task automatic test_flush;
    bit saw_done;
    issue(3'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b, expected 0", busy); end
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL flush_done: got done pulse, expected none"); end
    checks++;
    if ({hi, lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL flush_hold: got %h%h, expected %h%h", hi, lo, hi_m, lo_m); end
    // flush with start in IDLE issues nothing
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lo !== lo_m) begin errors++; $display("FAIL flush_start: got busy=%b lo=%h, expected 0 %h", busy, lo, lo_m); end
  endtask

  task automatic test_reset_mid;
    issue(3'd2, 32'h7654_3210, 32'd13);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    checks++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      errors++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b, expected all 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) x = x >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) y = 32'($signed(y) >>> $urandom_range(0, 31));
      run_op("random", o, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_ignore();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
